// File: rtl/dtw_ref_rd_arb_pkg.sv
// Shared definitions for the DTW reference-memory read arbiter: FSM encoding and default sizing.
package dtw_ref_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BLOCKED = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BURST_MAX = 16;

endpackage

// File: rtl/dtw_rr_pick.sv
// Combinational round-robin picker: one-hot winner among req, searching upward from last_owner+1.
module dtw_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic [NUM_REQ-1:0]         winner
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtw_ref_rd_arb.sv
// Round-robin burst arbiter sharing one reference-memory read port among DTW cores.
// Optional stall statistics output enabled by defining DTW_REF_ARB_STATS_EN.
module dtw_ref_rd_arb
  import dtw_ref_rd_arb_pkg::*;
#(
  parameter int NUM_REQ          = DEF_NUM_REQ,
  parameter int DATA_WIDTH       = 16,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int BURST_MAX        = DEF_BURST_MAX
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                ref_load_done_in,
  input  logic [NUM_REQ-1:0]                  req_in,
  input  logic [NUM_REQ*REFMEM_PTR_WIDTH-1:0] addr_in,
  output logic [NUM_REQ-1:0]                  gnt_out,
  output logic [REFMEM_PTR_WIDTH-1:0]         ref_addr_out,
  input  logic [DATA_WIDTH-1:0]               ref_data_in,
  output logic [DATA_WIDTH-1:0]               rdata_out,
  output logic [NUM_REQ-1:0]                  rvalid_out,
  output logic                                busy_out,
  output logic [1:0]                          dbg_state
`ifdef DTW_REF_ARB_STATS_EN
  ,
  output logic [31:0]                         dbg_stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_t                  state_reg, state_next;
  logic [NUM_REQ-1:0]          gnt_next;
  logic [IDX_W-1:0]            last_owner_reg;
  logic [IDX_W-1:0]            next_idx;
  logic [CNT_W-1:0]            beat_cnt_reg, beat_cnt_next, beat_cnt_inc;
  logic [NUM_REQ-1:0]          accept;
  logic [NUM_REQ-1:0]          pend_vld_reg;
  logic [NUM_REQ-1:0]          pick_gnt;
  logic                        any_req, owner_req;
  logic [REFMEM_PTR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [REFMEM_PTR_WIDTH-1:0] addr_sel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = addr_in[gi*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH];
  end

  assign any_req      = |req_in;
  assign accept       = req_in & gnt_out;
  assign owner_req    = |accept;
  assign beat_cnt_inc = beat_cnt_reg + 1'b1;

  // last_owner always tracks the current owner while granted, so the owner's own
  // bit is masked out and the search naturally starts at the next requester.
  dtw_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (req_in & ~gnt_out),
    .last_owner(last_owner_reg),
    .winner    (pick_gnt)
  );

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_out;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        gnt_next = '0;
        if (any_req) begin
          if (ref_load_done_in) begin
            state_next    = ST_GRANT;
            gnt_next      = pick_gnt;
            beat_cnt_next = '0;
          end else begin
            state_next = ST_BLOCKED;
          end
        end
      end
      ST_BLOCKED: begin
        gnt_next = '0;
        if (!any_req) begin
          state_next = ST_IDLE;
        end else if (ref_load_done_in) begin
          state_next    = ST_GRANT;
          gnt_next      = pick_gnt;
          beat_cnt_next = '0;
        end
      end
      ST_GRANT: begin
        if (!ref_load_done_in) begin
          state_next    = ST_BLOCKED;
          gnt_next      = '0;
          beat_cnt_next = '0;
        end else if (owner_req) begin
          if (beat_cnt_inc == CNT_W'(BURST_MAX)) begin
            beat_cnt_next = '0;
            if (|pick_gnt) gnt_next = pick_gnt;
          end else begin
            beat_cnt_next = beat_cnt_inc;
          end
        end else begin
          beat_cnt_next = '0;
          if (|pick_gnt) begin
            gnt_next = pick_gnt;
          end else begin
            state_next = ST_IDLE;
            gnt_next   = '0;
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        gnt_next      = '0;
        beat_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    next_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_next[i]) next_idx = IDX_W'(i);
    end
  end

  assign addr_sel = addr_arr[next_idx];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= ST_IDLE;
      gnt_out        <= '0;
      last_owner_reg <= IDX_W'(NUM_REQ - 1);
      beat_cnt_reg   <= '0;
      ref_addr_out   <= '0;
      pend_vld_reg   <= '0;
      rvalid_out     <= '0;
      rdata_out      <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_out      <= gnt_next;
      beat_cnt_reg <= beat_cnt_next;
      if (|gnt_next) begin
        last_owner_reg <= next_idx;
        ref_addr_out   <= addr_sel;
      end
      // Memory returns data one cycle after the address; capture it one more cycle later.
      pend_vld_reg <= accept;
      rvalid_out   <= pend_vld_reg;
      if (|pend_vld_reg) rdata_out <= ref_data_in;
    end
  end

  assign busy_out  = (state_reg != ST_IDLE) || (|pend_vld_reg);
  assign dbg_state = state_reg;

`ifdef DTW_REF_ARB_STATS_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_reg <= '0;
    end else if (any_req && !owner_req && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign dbg_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_dtw_ref_rd_arb.sv
// Directed self-checking bench for dtw_ref_rd_arb with a one-cycle registered memory model.
module tb_dtw_ref_rd_arb;

  logic        clk_in;
  logic        rst_in;
  logic        ref_load_done_in;
  logic [3:0]  req_in;
  logic [79:0] addr_in;
  logic [3:0]  gnt_out;
  logic [19:0] ref_addr_out;
  logic [15:0] ref_data_in;
  logic [15:0] rdata_out;
  logic [3:0]  rvalid_out;
  logic        busy_out;
  logic [1:0]  dbg_state;
`ifdef DTW_REF_ARB_STATS_EN
  logic [31:0] dbg_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  dtw_ref_rd_arb dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .ref_load_done_in(ref_load_done_in),
    .req_in          (req_in),
    .addr_in         (addr_in),
    .gnt_out         (gnt_out),
    .ref_addr_out    (ref_addr_out),
    .ref_data_in     (ref_data_in),
    .rdata_out       (rdata_out),
    .rvalid_out      (rvalid_out),
    .busy_out        (busy_out),
    .dbg_state       (dbg_state)
`ifdef DTW_REF_ARB_STATS_EN
    ,
    .dbg_stall_cnt   (dbg_stall_cnt)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] memf(input logic [19:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  always @(posedge clk_in) ref_data_in <= memf(ref_addr_out);

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic set_addr(input int i, input logic [19:0] a);
    addr_in[i*20 +: 20] = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] core_addr(input int i);
    return 20'h00100 + 20'(i * 'h11);
  endfunction

  initial begin
    logic [3:0] exp_v;
    int         own;

    rst_in = 1'b1; ref_load_done_in = 1'b0; req_in = '0; addr_in = '0;
    repeat (2) tick();
    chk("rst_gnt", 32'(gnt_out), 32'h0);
    chk("rst_rvalid", 32'(rvalid_out), 32'h0);
    chk("rst_rdata", 32'(rdata_out), 32'h0);
    chk("rst_addr", 32'(ref_addr_out), 32'h0);
    chk("rst_busy", 32'(busy_out), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);

    // Single core, one beat
    $display("step: single core read addr 5");
    rst_in = 1'b0; ref_load_done_in = 1'b1; set_addr(0, 20'd5); req_in = 4'b0001;
    tick();
    chk("t1_gnt", 32'(gnt_out), 32'h1);
    chk("t1_addr", 32'(ref_addr_out), 32'd5);
    chk("t1_state", 32'(dbg_state), 32'd1);
    chk("t1_rvalid0", 32'(rvalid_out), 32'h0);
    tick();
    chk("t1_gnt2", 32'(gnt_out), 32'h1);
    chk("t1_rvalid1", 32'(rvalid_out), 32'h0);
    chk("t1_busy", 32'(busy_out), 32'h1);
    req_in = 4'b0000;
    tick();
    chk("t1_rvalid", 32'(rvalid_out), 32'h1);
    chk("t1_rdata", 32'(rdata_out), 32'(memf(20'd5)));
    chk("t1_gnt_idle", 32'(gnt_out), 32'h0);
    chk("t1_state_idle", 32'(dbg_state), 32'd0);
    chk("t1_busy_idle", 32'(busy_out), 32'h0);
    tick();
    chk("t1_rvalid_end", 32'(rvalid_out), 32'h0);

    // Core 2 owns for 3 beats then drops; core 0 takes over with no gap
    $display("step: core 2 drops after 3 beats, core 0 pending");
    set_addr(2, 20'h20); set_addr(0, 20'h7); req_in = 4'b0101;
    tick();
    chk("t2_gnt_c2", 32'(gnt_out), 32'h4);
    chk("t2_addr_c2", 32'(ref_addr_out), 32'h20);
    tick();
    chk("t2_gnt_c2b", 32'(gnt_out), 32'h4);
    tick();
    chk("t2_rv1", 32'(rvalid_out), 32'h4);
    chk("t2_rd1", 32'(rdata_out), 32'(memf(20'h20)));
    tick();
    chk("t2_rv2", 32'(rvalid_out), 32'h4);
    chk("t2_gnt_c2c", 32'(gnt_out), 32'h4);
    req_in = 4'b0001;
    tick();
    chk("t2_gnt_c0", 32'(gnt_out), 32'h1);
    chk("t2_rv3", 32'(rvalid_out), 32'h4);
    chk("t2_addr_c0", 32'(ref_addr_out), 32'h7);
    tick();
    chk("t2_rv_gap", 32'(rvalid_out), 32'h0);
    chk("t2_gnt_c0b", 32'(gnt_out), 32'h1);
    req_in = 4'b0000;
    tick();
    chk("t2_rv_c0", 32'(rvalid_out), 32'h1);
    chk("t2_rd_c0", 32'(rdata_out), 32'(memf(20'h7)));
    chk("t2_gnt_end", 32'(gnt_out), 32'h0);
    chk("t2_state_end", 32'(dbg_state), 32'd0);

    // Blocked until the reference is loaded, then load drops mid-grant
    $display("step: blocked core 1, then load done toggles");
    ref_load_done_in = 1'b0; set_addr(1, 20'h33); req_in = 4'b0010;
    tick();
    chk("t3_state_blk", 32'(dbg_state), 32'd2);
    chk("t3_gnt_blk", 32'(gnt_out), 32'h0);
    chk("t3_busy_blk", 32'(busy_out), 32'h1);
    tick();
    chk("t3_state_blk2", 32'(dbg_state), 32'd2);
    ref_load_done_in = 1'b1;
    tick();
    chk("t3_gnt", 32'(gnt_out), 32'h2);
    chk("t3_addr", 32'(ref_addr_out), 32'h33);
    chk("t3_state_gnt", 32'(dbg_state), 32'd1);
    ref_load_done_in = 1'b0;
    tick();
    chk("t3_gnt_drop", 32'(gnt_out), 32'h0);
    chk("t3_state_reblk", 32'(dbg_state), 32'd2);
    tick();
    chk("t3_rv_inflight", 32'(rvalid_out), 32'h2);
    chk("t3_rd_inflight", 32'(rdata_out), 32'(memf(20'h33)));
    req_in = 4'b0000;
    tick();
    chk("t3_state_idle", 32'(dbg_state), 32'd0);
    chk("t3_busy_idle", 32'(busy_out), 32'h0);

    // Asynchronous reset mid-burst
    $display("step: reset mid-burst");
    ref_load_done_in = 1'b1;
    set_addr(0, 20'h11); set_addr(2, 20'h44); set_addr(3, 20'h55); req_in = 4'b1101;
    tick();
    chk("t4_gnt_c2", 32'(gnt_out), 32'h4);
    tick();
    tick();
    chk("t4_rv_pre", 32'(rvalid_out), 32'h4);
    rst_in = 1'b1;
    #1;
    chk("t4_gnt_rst", 32'(gnt_out), 32'h0);
    chk("t4_rv_rst", 32'(rvalid_out), 32'h0);
    chk("t4_rd_rst", 32'(rdata_out), 32'h0);
    chk("t4_addr_rst", 32'(ref_addr_out), 32'h0);
    chk("t4_busy_rst", 32'(busy_out), 32'h0);
    chk("t4_state_rst", 32'(dbg_state), 32'd0);
    tick();
    rst_in = 1'b0;
    tick();
    chk("t4_gnt_c0", 32'(gnt_out), 32'h1);
    chk("t4_addr_c0", 32'(ref_addr_out), 32'h11);
    chk("t4_rv_flush0", 32'(rvalid_out), 32'h0);
    tick();
    chk("t4_rv_flush1", 32'(rvalid_out), 32'h0);

    // All four cores request continuously: 16-beat rotation without bubbles
    $display("step: four-core rotation");
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, core_addr(i));
    req_in = 4'b1111;
    for (int k = 1; k <= 66; k++) begin
      tick();
      own   = ((k - 1) / 16) % 4;
      exp_v = 4'b0001 << own;
      chk($sformatf("t5_gnt_k%0d", k), 32'(gnt_out), 32'(exp_v));
      if (k >= 3) begin
        own   = ((k - 3) / 16) % 4;
        exp_v = 4'b0001 << own;
        chk($sformatf("t5_rv_k%0d", k), 32'(rvalid_out), 32'(exp_v));
        chk($sformatf("t5_rd_k%0d", k), 32'(rdata_out), 32'(memf(core_addr(own))));
      end
      if (k == 17) chk("t5_addr_c1", 32'(ref_addr_out), 32'(core_addr(1)));
    end

    // Lone requester past BURST_MAX keeps the grant
    $display("step: lone core 1 beyond burst limit");
    req_in = 4'b0010;
    for (int k = 67; k <= 110; k++) begin
      tick();
      chk($sformatf("t6_gnt_k%0d", k), 32'(gnt_out), 32'h2);
    end

`ifdef DTW_REF_ARB_STATS_EN
    $display("step: stall counter while blocked");
    req_in = 4'b0000;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("t7_stall_rst", dbg_stall_cnt, 32'd0);
    ref_load_done_in = 1'b0; req_in = 4'b0001;
    repeat (10) tick();
    chk("t7_stall_10", dbg_stall_cnt, 32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dtw_ref_rd_arb.md
DTW_REF_RD_ARB -- requirements
Module: dtw_ref_rd_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of DTW core requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, reference sample width.
REQ-003 SHALL have parameter REFMEM_PTR_WIDTH, default 20, reference memory address width.
REQ-004 SHALL have parameter BURST_MAX, default 16, maximum consecutive beats per grant while others wait.
REQ-005 SHALL have port clk_in  input  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port rst_in  input  1  asynchronous active-high reset.
REQ-007 SHALL have port ref_load_done_in  input  1  reference memory loaded and readable.
REQ-008 SHALL have port req_in  input  NUM_REQ  per-requester read request, one bit per core.
REQ-009 SHALL have port addr_in  input  NUM_REQ*REFMEM_PTR_WIDTH  packed read addresses; slice i belongs to core i.
REQ-010 SHALL have port gnt_out  output  NUM_REQ  one-hot registered grant; beat accepted when req_in[i] & gnt_out[i].
REQ-011 SHALL have port ref_addr_out  output  REFMEM_PTR_WIDTH  address driven to the reference memory read port.
REQ-012 SHALL have port ref_data_in  input  DATA_WIDTH  reference memory data, one-cycle registered read latency.
REQ-013 SHALL have port rdata_out  output  DATA_WIDTH  shared return data bus.
REQ-014 SHALL have port rvalid_out  output  NUM_REQ  one-hot return-valid qualifying rdata_out.
REQ-015 SHALL have port busy_out  output  1  high when state is not IDLE or a read is in flight.
REQ-016 SHALL have port dbg_state  output  2  current FSM state encoding.

Function
REQ-017 SHALL implement FSM states IDLE=0, GRANT=1, BLOCKED=2.
REQ-018 IDLE->GRANT when ref_load_done_in=1 and any req_in bit is high; IDLE->BLOCKED when ref_load_done_in=0 and any req_in bit is high.
REQ-019 BLOCKED->GRANT when ref_load_done_in rises with a request pending; BLOCKED->IDLE when all requests drop.
REQ-020 Winner SHALL be chosen round-robin, searching from index (last_owner+1) mod NUM_REQ; after reset last_owner=NUM_REQ-1, so index 0 wins first.
REQ-021 Grant SHALL appear on gnt_out the cycle after the request is sampled; ref_addr_out SHALL load addr_in slice of the requester whose beat is accepted, on the same edge.
REQ-022 rvalid_out[i] SHALL pulse and rdata_out SHALL equal ref_data_in exactly two cycles after beat acceptance; back-to-back beats SHALL sustain one read per cycle.
REQ-023 In GRANT, owner keeps grant while req_in[owner]=1 and beat count < BURST_MAX; beat counter resets on every ownership change.
REQ-024 At BURST_MAX beats with another request pending, grant SHALL rotate to the next round-robin requester with no bubble; with none pending, owner keeps grant and counter restarts.
REQ-025 Owner dropping req_in SHALL rotate grant the next cycle to the next pending requester, or return to IDLE with gnt_out=0 if none.
REQ-026 ref_load_done_in falling in GRANT SHALL clear gnt_out next cycle and enter BLOCKED; in-flight beats SHALL still return rvalid.
REQ-027 Simultaneous requests from all cores SHALL each be served within (NUM_REQ-1)*BURST_MAX+1 cycles of request.

Reset
REQ-028 rst_in high SHALL asynchronously force state IDLE, gnt_out=0, rvalid_out=0, rdata_out=0, ref_addr_out=0, busy_out=0, beat counter 0, last_owner=NUM_REQ-1; in-flight reads SHALL be discarded.

Configuration
REQ-029 With macro DTW_REF_ARB_STATS_EN defined, SHALL add output dbg_stall_cnt (32 bits), counting cycles where any req_in is high and no beat is accepted, saturating at all-ones, cleared by reset; without it, the port and counter SHALL not exist.

Structure
REQ-030 A shared package SHALL hold FSM state constants and the default NUM_REQ/BURST_MAX values.
REQ-031 Round-robin winner selection SHALL be one sub-module, dtw_rr_pick (request vector + last owner -> one-hot winner, combinational).

Verification
REQ-032 Single core: req_in=0001, addr 5, ref loaded -> gnt_out=0001 at t+1, ref_addr_out=5 at t+1, rvalid_out=0001 with mem[5] at t+3.
REQ-033 All four cores request continuously, BURST_MAX=16 -> grants rotate 0,1,2,3 every 16 beats, no idle cycles between owners.
REQ-034 ref_load_done_in=0 with req_in=0010 -> state BLOCKED, gnt_out=0; raise load done -> gnt_out=0010 next cycle.
REQ-035 Owner core 2 drops req after 3 beats, core 0 pending -> gnt_out=0001 next cycle; three rvalid pulses for core 2 still delivered.
REQ-036 rst_in asserted mid-burst -> all outputs 0 immediately; after release, index 0 wins first.
REQ-037 With DTW_REF_ARB_STATS_EN, 10 cycles of BLOCKED with request pending -> dbg_stall_cnt=10.
